// File: rtl/wt_dcache_rd_arb_if.sv
// Bundle of the arbiter's requester-facing and array-facing signals.
// The slave modport is the arbiter; the master modport is whatever drives
// the requests and the memory-array grant (a cache controller or a bench).
interface wt_dcache_rd_arb_if #(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned PayloadWidth = 64
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  // Requester side
  logic [NumPorts-1:0]                   req_i;
  logic [NumPorts-1:0]                   prio_i;
  logic [NumPorts-1:0][PayloadWidth-1:0] payload_i;
  logic [NumPorts-1:0]                   ack_o;
  logic [NumPorts-1:0]                   rsp_vld_o;

  // Array side
  logic                                  wr_cl_vld_i;
  logic                                  mem_req_o;
  logic [PayloadWidth-1:0]               mem_payload_o;
  logic [PortW-1:0]                      mem_port_o;
  logic                                  mem_gnt_i;

  // Status
  logic                                  starve_evt_o;

  modport slave (
    input  req_i, prio_i, payload_i, wr_cl_vld_i, mem_gnt_i,
    output ack_o, rsp_vld_o, mem_req_o, mem_payload_o, mem_port_o, starve_evt_o
  );

  modport master (
    output req_i, prio_i, payload_i, wr_cl_vld_i, mem_gnt_i,
    input  ack_o, rsp_vld_o, mem_req_o, mem_payload_o, mem_port_o, starve_evt_o
  );

endinterface

// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter in front of the write-through dcache data array.
// Three priority tiers (starved, high class, low class); round-robin inside
// the winning tier. The array answers a fixed one cycle after acceptance.
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned StarveLimit  = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  wt_dcache_rd_arb_if.slave bus
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned WaitW = $clog2(StarveLimit + 1);

  typedef logic [PortW-1:0] port_t;
  typedef logic [WaitW-1:0] wait_t;

  port_t               rr_q;
  wait_t               wait_q [NumPorts];
  logic [NumPorts-1:0] rsp_vld_q;
  logic                starve_evt_q;

  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] starved;
  logic [NumPorts-1:0] tier;
  port_t               sel;
  logic                mem_req;
  logic                accept;
  logic [NumPorts-1:0] ack;

  // Round-robin candidate: base + off wrapped into 0..NumPorts-1, so the
  // pointer never leaves the legal range even for non-power-of-two counts.
  function automatic port_t rr_index(input port_t base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumPorts) sum = sum - NumPorts;
    return port_t'(sum);
  endfunction

  // Eligibility and tier mask: starved beats high class beats low class.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path (defaults first); otherwise synthesis infers a latch.
    eligible = bus.req_i & {NumPorts{~bus.wr_cl_vld_i}};
    starved  = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      starved[k] = (wait_q[k] == wait_t'(StarveLimit));
    end
    if (|(eligible & starved)) begin
      tier = eligible & starved;
    end else if (|(eligible & bus.prio_i)) begin
      tier = eligible & bus.prio_i;
    end else begin
      tier = eligible;
    end
  end

  // Round-robin search upward from rr_q inside the winning tier.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!found && tier[rr_index(rr_q, i)]) begin
        sel   = rr_index(rr_q, i);
        found = 1'b1;
      end
    end
  end

  // Array request, selected payload/port and the same-cycle grant.
  always_comb begin
    mem_req = |eligible;
    accept  = mem_req & bus.mem_gnt_i;
    ack     = '0;
    if (accept) ack[sel] = 1'b1;
  end

  assign bus.mem_req_o     = mem_req;
  assign bus.mem_port_o    = mem_req ? sel : '0;
  assign bus.mem_payload_o = mem_req ? bus.payload_i[sel] : '0;
  assign bus.ack_o         = ack;
  assign bus.rsp_vld_o     = rsp_vld_q;
  assign bus.starve_evt_o  = starve_evt_q;

  // Round-robin pointer and the one-cycle response / starvation pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      rsp_vld_q    <= '0;
      starve_evt_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (accept) begin
        rr_q <= (sel == port_t'(NumPorts - 1)) ? '0 : sel + port_t'(1);
      end
      rsp_vld_q    <= ack;
      starve_evt_q <= accept & starved[sel];
    end
  end

  // Per-port wait counters, saturating at the starvation threshold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: this small counter array is reset explicitly because the
      // starvation decision reads it in the first cycle after reset.
      for (int unsigned k = 0; k < NumPorts; k++) wait_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        if (!bus.req_i[k] || ack[k]) begin
          wait_q[k] <= '0;
        end else if (!starved[k]) begin
          wait_q[k] <= wait_q[k] + wait_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Bench for wt_dcache_rd_arb: directed vectors push expected grants,
// responses and starvation pulses into queues; a negedge monitor pops and
// compares whenever the DUT presents one of those outputs.
module tb_wt_dcache_rd_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wt_dcache_rd_arb_if #(.NumPorts(3), .PayloadWidth(64)) bus3 ();
  wt_dcache_rd_arb_if #(.NumPorts(5), .PayloadWidth(64)) bus5 ();

  wt_dcache_rd_arb #(.NumPorts(3), .PayloadWidth(64), .StarveLimit(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus3.slave)
  );

  wt_dcache_rd_arb #(.NumPorts(5), .PayloadWidth(64), .StarveLimit(8)) dut5 (
    .clk_i(clk), .rst_i(rst), .bus(bus5.slave)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  ack;
    logic [1:0]  port;
    logic [63:0] payload;
  } ack_exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] vld;
  } rsp_exp_t;

  ack_exp_t    ack_q [$];
  rsp_exp_t    rsp_q [$];
  int          evt_q [$];
  logic [63:0] pay [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on the 3-port bus and record what must follow.
  task automatic step(input logic [2:0] req, input logic [2:0] prio, input logic wr,
                      input logic gnt, input logic [2:0] exp_ack, input int exp_port,
                      input bit exp_rsp, input bit exp_evt);
    @(posedge clk);
    #1;
    bus3.req_i       = req;
    bus3.prio_i      = prio;
    bus3.wr_cl_vld_i = wr;
    bus3.mem_gnt_i   = gnt;
    if (exp_ack != 3'b000) ack_q.push_back('{cyc, exp_ack, 2'(exp_port), pay[exp_port]});
    if (exp_rsp && exp_ack != 3'b000) rsp_q.push_back('{cyc + 1, exp_ack});
    if (exp_evt) evt_q.push_back(cyc + 1);
  endtask

  // One-cycle reset pulse with all requests dropped.
  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst              = 1'b1;
    bus3.req_i       = '0;
    bus3.prio_i      = '0;
    bus3.wr_cl_vld_i = 1'b0;
    bus3.mem_gnt_i   = 1'b0;
    @(negedge clk);
    check("rst_rsp_vld", bus3.rsp_vld_o, '0);
    check("rst_starve_evt", bus3.starve_evt_o, '0);
    check("rst_rr_q", dut.rr_q, '0);
    check("rst_mem_req", bus3.mem_req_o, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every grant, response and starvation pulse must be expected.
  always @(negedge clk) begin
    if (!rst && bus3.ack_o != 3'b000) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", bus3.ack_o, '0);
      end else begin
        ack_exp_t e;
        e = ack_q.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("ack_value", bus3.ack_o, e.ack);
        check("ack_port", bus3.mem_port_o, e.port);
        check("ack_payload", bus3.mem_payload_o, e.payload);
      end
    end
    if (bus3.rsp_vld_o != 3'b000) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", bus3.rsp_vld_o, '0);
      end else begin
        rsp_exp_t r;
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_value", bus3.rsp_vld_o, r.vld);
      end
    end
    if (bus3.starve_evt_o) begin
      if (evt_q.size() == 0) begin
        check("evt_unexpected", bus3.starve_evt_o, 1'b0);
      end else begin
        check("evt_cycle", cyc, evt_q.pop_front());
      end
    end
  end

  initial begin
    pay[0] = 64'h1111_2222_3333_0A00;
    pay[1] = 64'h4444_5555_6666_0B01;
    pay[2] = 64'h7777_8888_9999_0C02;
    bus3.req_i       = '0;
    bus3.prio_i      = '0;
    bus3.wr_cl_vld_i = 1'b0;
    bus3.mem_gnt_i   = 1'b0;
    for (int k = 0; k < 3; k++) bus3.payload_i[k] = pay[k];
    bus5.req_i       = '0;
    bus5.prio_i      = '0;
    bus5.wr_cl_vld_i = 1'b0;
    bus5.mem_gnt_i   = 1'b0;
    for (int k = 0; k < 5; k++) bus5.payload_i[k] = 64'(k + 16);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_rsp_vld", bus3.rsp_vld_o, '0);
    check("init_starve_evt", bus3.starve_evt_o, '0);
    check("init_mem_req", bus3.mem_req_o, '0);
    check("init_rr_q", dut.rr_q, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Port 2 low class starves behind ports 0/1, then wins via promotion
    for (int i = 0; i < 8; i++) begin
      step(3'b111, 3'b011, 1'b0, 1'b1, (i % 2 == 0) ? 3'b001 : 3'b010, i % 2, 1'b1, 1'b0);
    end
    step(3'b111, 3'b011, 1'b0, 1'b1, 3'b100, 2, 1'b1, 1'b1);
    // Acceptance followed at once by reset: its response is discarded
    step(3'b111, 3'b011, 1'b0, 1'b1, 3'b001, 0, 1'b0, 1'b0);
    rst_pulse();
    step(3'b110, 3'b000, 1'b0, 1'b1, 3'b010, 1, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);
    rst_pulse();

    // All high class: pure round-robin 0,1,2,0 with responses one cycle later
    step(3'b111, 3'b111, 1'b0, 1'b1, 3'b001, 0, 1'b1, 1'b0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 3'b010, 1, 1'b1, 1'b0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 3'b100, 2, 1'b1, 1'b0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 3'b001, 0, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);

    // Refill owns the array for 3 cycles; requesters keep counting
    for (int i = 0; i < 3; i++) begin
      step(3'b011, 3'b000, 1'b1, 1'b1, 3'b000, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("wr_mem_req", bus3.mem_req_o, 1'b0);
      check("wr_mem_port", bus3.mem_port_o, '0);
      check("wr_mem_payload", bus3.mem_payload_o, '0);
    end
    step(3'b011, 3'b000, 1'b0, 1'b1, 3'b010, 1, 1'b1, 1'b0);
    @(negedge clk);
    check("wr_wait0", dut.wait_q[0], 64'd3);
    check("wr_wait1", dut.wait_q[1], 64'd3);
    // Refill right after an acceptance: the response still arrives
    step(3'b011, 3'b000, 1'b1, 1'b1, 3'b000, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("wr_after_acc_mem_req", bus3.mem_req_o, 1'b0);
    step(3'b011, 3'b000, 1'b0, 1'b1, 3'b001, 0, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);

    // Array stalls for 5 cycles: selection held, no grant until gnt rises
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_mem_req", bus3.mem_req_o, 1'b1);
      check("stall_mem_port", bus3.mem_port_o, '0);
      check("stall_mem_payload", bus3.mem_payload_o, pay[0]);
    end
    step(3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 0, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);

    // Long stall saturates both counters; starvation outranks high class
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      step(3'b011, 3'b010, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);
    end
    step(3'b011, 3'b010, 1'b0, 1'b1, 3'b001, 0, 1'b1, 1'b1);
    @(negedge clk);
    check("sat_wait0", dut.wait_q[0], 64'd8);
    check("sat_wait1", dut.wait_q[1], 64'd8);
    step(3'b011, 3'b010, 1'b0, 1'b1, 3'b010, 1, 1'b1, 1'b1);
    step(3'b011, 3'b010, 1'b0, 1'b1, 3'b010, 1, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 0, 1'b0, 1'b0);

    // Five ports, all high class: pointer wraps 4 -> 0
    rst_pulse();
    @(posedge clk);
    #1;
    bus5.req_i     = 5'b11111;
    bus5.prio_i    = 5'b11111;
    bus5.mem_gnt_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [4:0] exp_ack5;
      exp_ack5 = 5'b00001 << (i % 5);
      @(negedge clk);
      check("p5_port", bus5.mem_port_o, 64'(i % 5));
      check("p5_ack", bus5.ack_o, exp_ack5);
      check("p5_port_range", (bus5.mem_port_o <= 3'd4), 1'b1);
      @(posedge clk);
      #1;
    end
    bus5.req_i     = '0;
    bus5.mem_gnt_i = 1'b0;

    repeat (3) @(negedge clk);
    check("ack_q_left", ack_q.size(), 0);
    check("rsp_q_left", rsp_q.size(), 0);
    check("evt_q_left", evt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wt_dcache_rd_arb.md
WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

Interface
REQ-001 Parameter NumPorts, default 3: number of cache read requesters; legal range 2..8.
REQ-002 Parameter PayloadWidth, default 64: width of the per-port request payload (tag, index and offset, packed).
REQ-003 Parameter StarveLimit, default 8: wait-cycle threshold for starvation promotion; legal range 2..255.
REQ-004 Derived constant PortW = max(1, clog2(NumPorts)).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_i  in  1  asynchronous reset, active-high.
REQ-008 req_i  in  NumPorts  per-port read request.
REQ-009 prio_i  in  NumPorts  per-port class: 1 = high, 0 = low.
REQ-010 payload_i  in  NumPorts x PayloadWidth  per-port request payload.
REQ-011 ack_o  out  NumPorts  one-hot grant, same cycle as acceptance.
REQ-012 wr_cl_vld_i  in  1  cacheline refill/invalidate owns the array this cycle.
REQ-013 mem_req_o  out  1  arbitrated request to the memory array.
REQ-014 mem_payload_o  out  PayloadWidth  payload of the selected port.
REQ-015 mem_port_o  out  PortW  index of the selected port.
REQ-016 mem_gnt_i  in  1  the array accepts the request this cycle.
REQ-017 rsp_vld_o  out  NumPorts  one-hot; read data valid for that port.
REQ-018 starve_evt_o  out  1  single-cycle pulse when a starved port is granted.

Function
REQ-019 A port SHALL be eligible when req_i[k]=1 and wr_cl_vld_i=0; wr_cl_vld_i=1 forces mem_req_o=0 and ack_o=0.
REQ-020 Selection order SHALL be: starved eligible ports, then high-class eligible ports, then low-class eligible ports.
REQ-021 Within the winning tier, selection SHALL be round-robin, searching upward from pointer rr_q and wrapping from NumPorts-1 to 0.
REQ-022 mem_req_o SHALL equal OR of the eligible ports; mem_payload_o and mem_port_o SHALL reflect the selected port; both are 0 when mem_req_o=0.
REQ-023 Acceptance occurs when mem_req_o=1 and mem_gnt_i=1; ack_o[sel]=1 in that cycle only; ack_o is combinational.
REQ-024 On acceptance, rr_q SHALL be set to (sel+1) mod NumPorts; otherwise it holds.
REQ-025 Per-port counter wait_q[k] SHALL reset to 0 when req_i[k]=0 or ack_o[k]=1, increment when req_i[k]=1 and ack_o[k]=0, and saturate at StarveLimit.
REQ-026 Port k SHALL be starved when wait_q[k]=StarveLimit.
REQ-027 starve_evt_o SHALL be registered: high for one cycle after acceptance of a starved port.
REQ-028 rsp_vld_o SHALL be registered: rsp_vld_o[k]=1 exactly one cycle after ack_o[k]=1 (fixed 1-cycle array latency); back-to-back acceptances SHALL yield back-to-back responses.
REQ-029 A request withdrawn before acceptance SHALL be dropped without a response; the selection may change freely while mem_gnt_i=0.
REQ-030 If wr_cl_vld_i=1 in a cycle, the response of an acceptance in the previous cycle SHALL still be delivered.
REQ-031 If NumPorts is not a power of two, rr_q SHALL never take a value >= NumPorts.

Reset
REQ-032 While rst_i=1: rr_q=0, wait_q=0 for all ports, rsp_vld_o=0, starve_evt_o=0; the combinational outputs follow from the inputs with this state.
REQ-033 Reset asserted mid-operation SHALL discard any pending response; no rsp_vld_o pulse is produced in the first cycle after deassertion.

Verification
REQ-034 NumPorts=3, req_i=111, prio_i=011, mem_gnt_i=1 held -> grants 0,1,0,1 while port 2 waits; after 8 waits port 2 is granted and starve_evt_o pulses once in the following cycle.
REQ-035 req_i=111, prio_i=111, mem_gnt_i=1 -> ack_o sequence 001,010,100,001; rsp_vld_o shows the same sequence delayed by one cycle.
REQ-036 wr_cl_vld_i=1 for 3 cycles with req_i=011 -> mem_req_o=0 and ack_o=0 throughout; wait_q[0] and wait_q[1] both reach 3; arbitration resumes in the next cycle.
REQ-037 mem_gnt_i=0 for 5 cycles with req_i=001 -> mem_port_o=0 and mem_payload_o=payload_i[0] held stable, no ack_o; grant occurs in the cycle mem_gnt_i rises.
REQ-038 rst_i pulsed in the cycle after an acceptance -> no rsp_vld_o pulse; rr_q=0, so the next grant with req_i=110 goes to port 1.
REQ-039 NumPorts=5, all ports requesting high class -> rr_q wraps 4->0; the port index never exceeds 4.
